// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, bus width,
// fetch-exception bit positions and FSM state encodings.
package if_stage_pkg;

  localparam int          FS_TO_DS_BUS_WD = 32;
  localparam logic [31:0] RESET_PC        = 32'h1c00_0000;

  // Bit positions inside csr_vec_h
  localparam int          CSR_ADEF        = 0;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } fs_state_e;

  // Fetch address is misaligned when either of the two low bits is set.
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return |pc[1:0];
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the PC, drives the synchronous instruction
// SRAM and hands the fetch PC plus fetch-exception bits to the decode stage.
// Redirects arriving while IF is stalled are parked in a one-entry buffer.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          FS_TO_DS_BUS_WD = if_stage_pkg::FS_TO_DS_BUS_WD,
  parameter logic [31:0] RESET_PC        = if_stage_pkg::RESET_PC
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [31:0]                new_pc,
  input  logic [5:0]                 stall,
  input  logic                       br_taken,
  input  logic [31:0]                br_target,
  output logic                       pc_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic [31:0]                csr_vec_h,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata
);

  fs_state_e   state, state_nxt;
  logic [31:0] pc_r, pc_nxt;
  logic        pend_valid, pend_valid_nxt;
  logic [31:0] pend_pc, pend_pc_nxt;
  // One-cycle bubble following a flush: the new PC is presented but not
  // marked valid, and the PC is held so the target is fetched next cycle.
  logic        bubble_r, bubble_nxt;
  logic        if_hold;
  logic        stall_hi_unused;

  assign if_hold         = stall[0];
  // Only the IF hold bit of the shared stall vector matters here.
  assign stall_hi_unused = ^stall[5:1];

  // Next-state, next-PC and pending-redirect selection
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc_r;
    pend_valid_nxt = pend_valid;
    pend_pc_nxt    = pend_pc;
    bubble_nxt     = 1'b0;
    case (state)
      S_BOOT: begin
        // First fetch after reset is RESET_PC itself, so the PC is kept.
        state_nxt = S_RUN;
      end
      default: begin
        if (flush) begin
          // Flush wins over everything, stall included, and drops any
          // parked branch target.
          pc_nxt         = new_pc;
          pend_valid_nxt = 1'b0;
          state_nxt      = S_RUN;
          bubble_nxt     = 1'b1;
        end else if (br_taken) begin
          if (!if_hold) begin
            pc_nxt         = br_target;
            pend_valid_nxt = 1'b0;
            state_nxt      = S_RUN;
          end else begin
            // Youngest EX redirect overwrites any older parked target.
            pend_pc_nxt    = br_target;
            pend_valid_nxt = 1'b1;
            state_nxt      = S_PEND;
          end
        end else if (pend_valid && !if_hold) begin
          pc_nxt         = pend_pc;
          pend_valid_nxt = 1'b0;
          state_nxt      = S_RUN;
        end else if (if_hold) begin
          // Hold everything so SRAM rdata stays stable for decode replay.
          pc_nxt = pc_r;
        end else if (bubble_r) begin
          pc_nxt = pc_r;
        end else begin
          // 32-bit modulo increment; wraps silently at the top of memory.
          pc_nxt = pc_r + 32'd4;
        end
      end
    endcase
  end

  // State, PC and pending-redirect registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_BOOT;
      pc_r       <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
      bubble_r   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_r       <= pc_nxt;
      pend_valid <= pend_valid_nxt;
      pend_pc    <= pend_pc_nxt;
      bubble_r   <= bubble_nxt;
    end
  end

  // Outputs are a pure function of registered state.
  always_comb begin
    pc_valid            = (state != S_BOOT) && !bubble_r;
    csr_vec_h           = 32'h0;
    csr_vec_h[CSR_ADEF] = pc_valid && pc_misaligned(pc_r);
    inst_sram_en        = pc_valid && !pc_misaligned(pc_r);
  end

  assign fs_to_ds_bus    = FS_TO_DS_BUS_WD'(pc_r);
  assign inst_sram_addr  = pc_r;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;

endmodule
